// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module  : icache_pkg
// Brief   : Shared state encoding and width helpers for the direct-mapped I-cache.
// Rev     : 1.0  initial release
// ============================================================================
package icache_pkg;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_REFILL = 1'b1
   } state_t;

   function automatic int off_bits(input int bits_line);
      return $clog2(bits_line / 8);
   endfunction

   function automatic int idx_bits(input int num_lines);
      return $clog2(num_lines);
   endfunction

   function automatic int tag_bits(input int addr_width, input int num_lines, input int bits_line);
      return addr_width - idx_bits(num_lines) - off_bits(bits_line);
   endfunction

   function automatic int word_lsb(input int data_width);
      return $clog2(data_width / 8);
   endfunction

   // Word index within a line; byte bits below one word are dropped.
   function automatic logic [31:0] word_sel(input logic [63:0] addr, input int data_width,
                                            input int bits_line);
      logic [63:0] w_sh;
      w_sh = addr >> word_lsb(data_width);
      return 32'(w_sh & 64'((bits_line / data_width) - 1));
   endfunction

endpackage
`default_nettype wire

// File: rtl/icache_tag_array.sv
`default_nettype none
// ============================================================================
// Module  : icache_tag_array
// Brief   : Tag and valid storage: one read port, one fill port, global clear.
// Rev     : 1.0  initial release
// ============================================================================
module icache_tag_array #(
   parameter int NUM_LINES = 4,
   parameter int IDX_BITS  = 2,
   parameter int TAG_BITS  = 26
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_BITS-1:0] i_rd_idx,
   output logic [TAG_BITS-1:0] o_rd_tag,
   output logic                o_rd_valid,
   input  logic                i_wr_en,
   input  logic [IDX_BITS-1:0] i_wr_idx,
   input  logic [TAG_BITS-1:0] i_wr_tag,
   input  logic                i_wr_valid,
   input  logic                i_clr
);

   logic [NUM_LINES-1:0] r_valid;
   logic [TAG_BITS-1:0]  r_tag [NUM_LINES];

   // A fill on the same edge as a clear keeps its own valid value for that line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
      end else begin
         if (i_clr)
            r_valid <= '0;
         if (i_wr_en)
            r_valid[i_wr_idx] <= i_wr_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (i_wr_en)
         r_tag[i_wr_idx] <= i_wr_tag;
   end

   assign o_rd_tag   = r_tag[i_rd_idx];
   assign o_rd_valid = r_valid[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/icache_dm_refill.sv
`default_nettype none
// ============================================================================
// Module  : icache_dm_refill
// Brief   : Direct-mapped instruction cache, combinational hit, line refill on miss.
//           Define ICACHE_STATS_EN to add hit_count / miss_count outputs.
// Rev     : 1.0  initial release
// ============================================================================
module icache_dm_refill
   import icache_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_LINES  = 4,
   parameter int BITS_LINE  = 128
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] addrInst,
   output logic [DATA_WIDTH-1:0] instr,
   output logic                  cache_miss,
   input  logic                  inval,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [BITS_LINE-1:0]  mem_rdata
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
`endif
);

   localparam int c_OFF_BITS = off_bits(BITS_LINE);
   localparam int c_IDX_BITS = idx_bits(NUM_LINES);
   localparam int c_TAG_BITS = tag_bits(ADDR_WIDTH, NUM_LINES, BITS_LINE);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_mem_addr;
   logic                    r_pend_inval;
   logic                    w_pend_nxt;
   logic                    w_latch;
   logic                    w_fill;
   logic                    w_fill_valid;
   logic                    w_clr;

   logic [c_IDX_BITS-1:0]   w_idx;
   logic [c_TAG_BITS-1:0]   w_tag;
   logic [c_IDX_BITS-1:0]   w_fill_idx;
   logic [c_TAG_BITS-1:0]   w_fill_tag;
   logic [c_TAG_BITS-1:0]   w_rd_tag;
   logic                    w_rd_valid;
   logic                    w_hit;
   logic [31:0]             w_wsel;
   logic [BITS_LINE-1:0]    w_line;
   logic [ADDR_WIDTH-1:0]   w_line_addr;

   logic [BITS_LINE-1:0]    r_data [NUM_LINES];

   assign w_idx       = addrInst[c_OFF_BITS +: c_IDX_BITS];
   assign w_tag       = addrInst[ADDR_WIDTH-1 -: c_TAG_BITS];
   assign w_fill_idx  = r_mem_addr[c_OFF_BITS +: c_IDX_BITS];
   assign w_fill_tag  = r_mem_addr[ADDR_WIDTH-1 -: c_TAG_BITS];
   assign w_line_addr = {addrInst[ADDR_WIDTH-1:c_OFF_BITS], {c_OFF_BITS{1'b0}}};

   icache_tag_array #(
      .NUM_LINES (NUM_LINES),
      .IDX_BITS  (c_IDX_BITS),
      .TAG_BITS  (c_TAG_BITS)
   ) u_tags (
      .clk        (clk),
      .rst        (reset),
      .i_rd_idx   (w_idx),
      .o_rd_tag   (w_rd_tag),
      .o_rd_valid (w_rd_valid),
      .i_wr_en    (w_fill),
      .i_wr_idx   (w_fill_idx),
      .i_wr_tag   (w_fill_tag),
      .i_wr_valid (w_fill_valid),
      .i_clr      (w_clr)
   );

   // Lookups only count in IDLE; during a refill the fetch stage is always stalled.
   assign w_hit      = (r_state == ST_IDLE) && w_rd_valid && (w_rd_tag == w_tag);
   assign w_wsel     = word_sel(64'(addrInst), DATA_WIDTH, BITS_LINE);
   assign w_line     = r_data[w_idx];
   assign instr      = w_hit ? w_line[w_wsel*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign cache_miss = ~w_hit;
   assign mem_req    = (r_state == ST_REFILL);
   assign mem_addr   = r_mem_addr;

   always_comb begin
      w_state_nxt  = r_state;
      w_pend_nxt   = r_pend_inval;
      w_latch      = 1'b0;
      w_fill       = 1'b0;
      w_fill_valid = 1'b0;
      w_clr        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_clr = inval;
            if (!w_hit) begin
               w_state_nxt = ST_REFILL;
               w_latch     = 1'b1;
            end
         end
         ST_REFILL: begin
            if (mem_ack) begin
               // An invalidate seen at any point in the refill also kills the fresh line.
               w_fill       = 1'b1;
               w_fill_valid = ~(r_pend_inval | inval);
               w_clr        = r_pend_inval | inval;
               w_pend_nxt   = 1'b0;
               w_state_nxt  = ST_IDLE;
            end else if (inval) begin
               w_pend_nxt = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_mem_addr   <= '0;
         r_pend_inval <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pend_inval <= w_pend_nxt;
         if (w_latch)
            r_mem_addr <= w_line_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (w_fill)
         r_data[w_fill_idx] <= mem_rdata;
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_hit)
            r_hit_cnt <= r_hit_cnt + 32'd1;
         if (w_latch)
            r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign hit_count  = r_hit_cnt;
   assign miss_count = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_dm_refill.sv
`default_nettype none
// ============================================================================
// Module  : tb_icache_dm_refill
// Brief   : Directed table-driven bench for icache_dm_refill (ICACHE_STATS_EN optional).
// Rev     : 1.0  initial release
// ============================================================================
module tb_icache_dm_refill;

   logic         clk;
   logic         reset;
   logic [31:0]  addrInst;
   logic [31:0]  instr;
   logic         cache_miss;
   logic         inval;
   logic         mem_req;
   logic [31:0]  mem_addr;
   logic         mem_ack;
   logic [127:0] mem_rdata;
`ifdef ICACHE_STATS_EN
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;
`endif

   int n_cmp;
   int n_bad;

   localparam logic [127:0] c_L0 = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
   localparam logic [127:0] c_L1 = {32'h44440013, 32'h33330012, 32'h22220011, 32'h11110010};
   localparam logic [127:0] c_L4 = {32'h99990043, 32'h88880042, 32'h77770041, 32'h66660040};

   icache_dm_refill dut (
      .clk        (clk),
      .reset      (reset),
      .addrInst   (addrInst),
      .instr      (instr),
      .cache_miss (cache_miss),
      .inval      (inval),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        miss;
      logic [31:0] word;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Called in REFILL just after a negedge; returns one cycle later in IDLE.
   task automatic ack_line(input logic [127:0] line);
      mem_ack   = 1'b1;
      mem_rdata = line;
      tick();
      mem_ack   = 1'b0;
      #1;
   endtask

   vec_t tbl [8];

   initial begin
      n_cmp = 0;
      n_bad = 0;
      tbl[0] = '{32'h0000_0000, 1'b0, 32'hAAAA0000};
      tbl[1] = '{32'h0000_0004, 1'b0, 32'hBBBB0001};
      tbl[2] = '{32'h0000_0008, 1'b0, 32'hCCCC0002};
      tbl[3] = '{32'h0000_000C, 1'b0, 32'hDDDD0003};
      tbl[4] = '{32'h0000_0002, 1'b0, 32'hAAAA0000};
      tbl[5] = '{32'h0000_000F, 1'b0, 32'hDDDD0003};
      tbl[6] = '{32'h0000_0009, 1'b0, 32'hCCCC0002};
      tbl[7] = '{32'h0000_0010, 1'b1, 32'h0000_0000};

      reset = 1'b1; addrInst = '0; inval = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rst_miss", 64'(cache_miss), 64'd1);
      chk("rst_instr", 64'(instr), 64'd0);
      chk("rst_req", 64'(mem_req), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);

      tick(); #1;
      chk("refill_req", 64'(mem_req), 64'd1);
      chk("refill_addr", 64'(mem_addr), 64'd0);
      tick(); addrInst = 32'h4; #1;
      chk("refill_stall", 64'(cache_miss), 64'd1);
      chk("refill_addr_stable", 64'(mem_addr), 64'd0);
      tick(); addrInst = 32'h0; #1;
      ack_line(c_L0);
      chk("post_ack_req", 64'(mem_req), 64'd0);
      chk("post_ack_miss", 64'(cache_miss), 64'd0);

      for (int i = 0; i < 8; i++) begin
         tick();
         addrInst = tbl[i].addr;
         #1;
         chk($sformatf("tbl%0d_miss", i), 64'(cache_miss), 64'(tbl[i].miss));
         chk($sformatf("tbl%0d_instr", i), 64'(instr), 64'(tbl[i].word));
      end

      tick(); #1;
      chk("l1_req", 64'(mem_req), 64'd1);
      chk("l1_addr", 64'(mem_addr), 64'h10);
      addrInst = 32'h0; #1;
      chk("l1_stall_any_addr", 64'(cache_miss), 64'd1);
      addrInst = 32'h14;
      ack_line(c_L1);
      chk("l1_word1", 64'(instr), 64'h22220011);
      addrInst = 32'h8; #1;
      chk("l0_kept", 64'(instr), 64'hCCCC0002);

      // ack while IDLE must not disturb anything
      mem_ack = 1'b1; mem_rdata = '1;
      tick();
      mem_ack = 1'b0; #1;
      chk("idle_ack_instr", 64'(instr), 64'hCCCC0002);
      chk("idle_ack_req", 64'(mem_req), 64'd0);

      // conflict on idx 0
      addrInst = 32'h40; #1;
      chk("conf_miss", 64'(cache_miss), 64'd1);
      tick(); #1;
      chk("conf_addr", 64'(mem_addr), 64'h40);
      ack_line(c_L4);
      chk("conf_hit", 64'(instr), 64'h66660040);
      addrInst = 32'h0; #1;
      chk("conf_evict", 64'(cache_miss), 64'd1);
      tick(); #1;
      chk("conf_back_addr", 64'(mem_addr), 64'h0);
      ack_line(c_L0);
      chk("conf_back_hit", 64'(instr), 64'hAAAA0000);

      // invalidate in IDLE: same-cycle lookup still hits
      inval = 1'b1; #1;
      chk("inval_same_cycle", 64'(cache_miss), 64'd0);
      tick(); inval = 1'b0;
      addrInst = 32'h14; #1;
      chk("inval_l1_gone", 64'(cache_miss), 64'd1);
      addrInst = 32'h0; #1;
      chk("inval_l0_gone", 64'(cache_miss), 64'd1);
      tick(); #1;
      chk("inval_refill_req", 64'(mem_req), 64'd1);
      inval = 1'b1;
      tick(); inval = 1'b0; #1;
      ack_line(c_L0);
      chk("pend_inval_miss", 64'(cache_miss), 64'd1);
      tick(); #1;
      chk("pend_inval_rereq", 64'(mem_req), 64'd1);
      inval = 1'b1;
      ack_line(c_L0);
      inval = 1'b0; #1;
      chk("inval_ack_same_edge", 64'(cache_miss), 64'd1);

      // async reset two cycles into a refill
      tick(); #1;
      chk("pre_rst_req", 64'(mem_req), 64'd1);
      tick(); #2;
      reset = 1'b1; #1;
      chk("async_rst_req", 64'(mem_req), 64'd0);
      chk("async_rst_addr", 64'(mem_addr), 64'd0);
      addrInst = 32'h40; #1;
      chk("async_rst_miss40", 64'(cache_miss), 64'd1);
      addrInst = 32'h10; #1;
      chk("async_rst_miss10", 64'(cache_miss), 64'd1);
      addrInst = 32'h0;
      tick();
      reset = 1'b0; #1;
      chk("post_rst_miss0", 64'(cache_miss), 64'd1);

`ifdef ICACHE_STATS_EN
      chk("stat_hit0", 64'(hit_count), 64'd0);
      tick(); #1;
      ack_line(c_L0);
      repeat (4) tick();
      #1;
      chk("stat_miss", 64'(miss_count), 64'd1);
      chk("stat_hit", 64'(hit_count), 64'd4);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
